bsg_manycore_io_inject_arbiter: RTL and testbench

- Shares the single pass-through injection port of the IO complex's south-edge monitor among several packet sources (SPMD loader, host bridge, trace replayer).
- Performs round-robin arbitration, holds the winning packet in a registered output stage, and enforces an end-to-end outgoing credit limit.
- Provides a drain sequence so the testbench can quiesce injection and learn when every issued packet has been acknowledged.

---
 rtl/bsg_manycore_io_inject_arbiter.sv | 186 ++++++++++++++++++
 tb/tb_bsg_manycore_io_inject_arbiter.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/bsg_manycore_io_inject_arbiter.sv
// Round-robin arbiter feeding the IO monitor's pass-through injection port, with an
// outgoing credit limit and a drain handshake. Define BSG_MANYCORE_IO_ARB_STATS_EN for stats counters.
module bsg_manycore_io_inject_arbiter #(
    parameter int unsigned packet_width_p    = 32,
    parameter int unsigned num_req_p         = 2,
    parameter int unsigned max_out_credits_p = 128,
    localparam int unsigned credit_width_lp  = (max_out_credits_p > 0) ? $clog2(max_out_credits_p + 1) : 1,
    localparam int unsigned id_width_lp      = (num_req_p > 1) ? $clog2(num_req_p) : 1
) (
    input  logic                                clk_i,
    input  logic                                reset_i,
    input  logic [num_req_p-1:0]                req_v_i,
    input  logic [num_req_p*packet_width_p-1:0] req_data_i,
    output logic [num_req_p-1:0]                req_ready_o,
    output logic [packet_width_p-1:0]           data_o,
    output logic                                v_o,
    input  logic                                ready_i,
    output logic [id_width_lp-1:0]              grant_id_o,
    input  logic                                credit_return_i,
    output logic [credit_width_lp-1:0]          out_credits_o,
    input  logic                                drain_i,
    output logic                                drained_o,
`ifdef BSG_MANYCORE_IO_ARB_STATS_EN
    output logic [num_req_p*32-1:0]             stat_pkts_o,
    output logic [31:0]                         stat_stall_o,
    input  logic                                stat_clear_i,
`endif
    output logic                                overflow_o
);

    localparam logic [credit_width_lp-1:0] max_credits_lp = credit_width_lp'(max_out_credits_p);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    state_e                      state_q, state_d;
    logic [packet_width_p-1:0]   data_q, data_d;
    logic                        v_q, v_d;
    logic [id_width_lp-1:0]      grant_q, grant_d;
    logic [id_width_lp-1:0]      rr_ptr_q, rr_ptr_d;
    logic [credit_width_lp-1:0]  credits_q, credits_d;
    logic                        overflow_q, overflow_d;

    logic                        found;
    logic [id_width_lp-1:0]      winner;
    logic [id_width_lp-1:0]      cand;
    int unsigned                 idx;
    logic                        can_load;
    logic                        accept;

    // First valid requester at or after the round-robin pointer, wrapping.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        idx    = 0;
        cand   = '0;
        for (int unsigned i = 0; i < num_req_p; i++) begin
            idx = 32'(rr_ptr_q) + i;
            if (idx >= num_req_p) begin
                idx = idx - num_req_p;
            end
            cand = id_width_lp'(idx);
            if (!found && req_v_i[cand]) begin
                found  = 1'b1;
                winner = cand;
            end
        end
    end

    // Output stage reloads when empty or draining into the monitor this cycle.
    assign can_load = !v_q || ready_i;
    assign accept   = !reset_i && (state_q == ST_RUN) && !drain_i && can_load
                      && (credits_q != '0) && found;

    always_comb begin
        state_d    = state_q;
        data_d     = data_q;
        v_d        = v_q;
        grant_d    = grant_q;
        rr_ptr_d   = rr_ptr_q;
        credits_d  = credits_q;
        overflow_d = overflow_q;

        if (accept) begin
            data_d   = req_data_i[winner*packet_width_p +: packet_width_p];
            grant_d  = winner;
            v_d      = 1'b1;
            rr_ptr_d = (32'(winner) == num_req_p - 1) ? '0 : id_width_lp'(32'(winner) + 1);
        end else if (v_q && ready_i) begin
            v_d = 1'b0;
        end

        if (accept && !credit_return_i) begin
            credits_d = credits_q - credit_width_lp'(1);
        end else if (!accept && credit_return_i) begin
            if (credits_q == max_credits_lp) begin
                overflow_d = 1'b1;
            end else begin
                credits_d = credits_q + credit_width_lp'(1);
            end
        end

        unique case (state_q)
            ST_RUN: begin
                if (drain_i) state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (!drain_i) begin
                    state_d = ST_RUN;
                end else if (!v_q && (credits_q == max_credits_lp)) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (!drain_i) state_d = ST_RUN;
            end
            default: state_d = ST_RUN;
        endcase
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q    <= ST_RUN;
            data_q     <= '0;
            v_q        <= 1'b0;
            grant_q    <= '0;
            rr_ptr_q   <= '0;
            credits_q  <= max_credits_lp;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            data_q     <= data_d;
            v_q        <= v_d;
            grant_q    <= grant_d;
            rr_ptr_q   <= rr_ptr_d;
            credits_q  <= credits_d;
            overflow_q <= overflow_d;
        end
    end

    assign req_ready_o   = accept ? (num_req_p'(1) << winner) : '0;
    assign data_o        = data_q;
    assign v_o           = v_q;
    assign grant_id_o    = grant_q;
    assign out_credits_o = credits_q;
    assign drained_o     = (state_q == ST_DONE);
    assign overflow_o    = overflow_q;

`ifdef BSG_MANYCORE_IO_ARB_STATS_EN
    logic [num_req_p*32-1:0] pkts_q, pkts_d;
    logic [31:0]             stall_q, stall_d;

    always_comb begin
        pkts_d  = pkts_q;
        stall_d = stall_q;
        if (stat_clear_i) begin
            pkts_d  = '0;
            stall_d = '0;
        end else begin
            if (accept) begin
                pkts_d[winner*32 +: 32] = pkts_q[winner*32 +: 32] + 32'd1;
            end
            if ((|req_v_i) && !accept) begin
                stall_d = stall_q + 32'd1;
            end
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            pkts_q  <= '0;
            stall_q <= '0;
        end else begin
            pkts_q  <= pkts_d;
            stall_q <= stall_d;
        end
    end

    assign stat_pkts_o  = pkts_q;
    assign stat_stall_o = stall_q;
`endif

endmodule

// File: tb/tb_bsg_manycore_io_inject_arbiter.sv
// Directed bench for bsg_manycore_io_inject_arbiter: a 128-credit instance and a 4-credit instance.
module tb_bsg_manycore_io_inject_arbiter;

    localparam int unsigned PW = 16;

    logic clk;
    logic reset_i;

    logic [1:0]    req_v;
    logic [2*PW-1:0] req_data;
    logic [1:0]    req_ready;
    logic [PW-1:0] data_o;
    logic          v_o;
    logic          ready;
    logic          grant_id;
    logic          cret;
    logic [7:0]    credits;
    logic          drain;
    logic          drained;
    logic          overflow;

    logic [1:0]    r4_v;
    logic [2*PW-1:0] r4_data;
    logic [1:0]    r4_ready;
    logic [PW-1:0] r4_data_o;
    logic          r4_v_o;
    logic          r4_ready_i;
    logic          r4_grant;
    logic          r4_cret;
    logic [2:0]    r4_credits;
    logic          r4_drain;
    logic          r4_drained;
    logic          r4_overflow;

`ifdef BSG_MANYCORE_IO_ARB_STATS_EN
    logic [63:0] stat_pkts, r4_stat_pkts;
    logic [31:0] stat_stall, r4_stat_stall;
`endif

    int n_cmp  = 0;
    int n_fail = 0;

    bsg_manycore_io_inject_arbiter #(
        .packet_width_p(PW), .num_req_p(2), .max_out_credits_p(128)
    ) dut (
        .clk_i(clk), .reset_i(reset_i),
        .req_v_i(req_v), .req_data_i(req_data), .req_ready_o(req_ready),
        .data_o(data_o), .v_o(v_o), .ready_i(ready), .grant_id_o(grant_id),
        .credit_return_i(cret), .out_credits_o(credits),
        .drain_i(drain), .drained_o(drained),
`ifdef BSG_MANYCORE_IO_ARB_STATS_EN
        .stat_pkts_o(stat_pkts), .stat_stall_o(stat_stall), .stat_clear_i(1'b0),
`endif
        .overflow_o(overflow)
    );

    bsg_manycore_io_inject_arbiter #(
        .packet_width_p(PW), .num_req_p(2), .max_out_credits_p(4)
    ) dut4 (
        .clk_i(clk), .reset_i(reset_i),
        .req_v_i(r4_v), .req_data_i(r4_data), .req_ready_o(r4_ready),
        .data_o(r4_data_o), .v_o(r4_v_o), .ready_i(r4_ready_i), .grant_id_o(r4_grant),
        .credit_return_i(r4_cret), .out_credits_o(r4_credits),
        .drain_i(r4_drain), .drained_o(r4_drained),
`ifdef BSG_MANYCORE_IO_ARB_STATS_EN
        .stat_pkts_o(r4_stat_pkts), .stat_stall_o(r4_stat_stall), .stat_clear_i(1'b0),
`endif
        .overflow_o(r4_overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        req_v = '0; req_data = '0; ready = 1'b1; cret = 1'b0; drain = 1'b0;
        r4_v = '0; r4_data = '0; r4_ready_i = 1'b1; r4_cret = 1'b0; r4_drain = 1'b0;
        reset_i = 1'b1;
        #2;
        reset_i = 1'b0;
        tick();
    endtask

    task automatic test_reset;
        reset_i = 1'b1;
        req_v = 2'b11; req_data = {16'h2222, 16'h1111}; ready = 1'b1; cret = 1'b0; drain = 1'b0;
        r4_v = '0; r4_data = '0; r4_ready_i = 1'b1; r4_cret = 1'b0; r4_drain = 1'b0;
        #3;
        n_cmp++; if (v_o !== 1'b0) begin n_fail++; $display("FAIL rst_v: got %0b want 0", v_o); end
        n_cmp++; if (data_o !== 16'h0) begin n_fail++; $display("FAIL rst_data: got %h want 0000", data_o); end
        n_cmp++; if (grant_id !== 1'b0) begin n_fail++; $display("FAIL rst_grant: got %0b want 0", grant_id); end
        n_cmp++; if (req_ready !== 2'b00) begin n_fail++; $display("FAIL rst_ready: got %b want 00", req_ready); end
        n_cmp++; if (credits !== 8'd128) begin n_fail++; $display("FAIL rst_credits: got %0d want 128", credits); end
        n_cmp++; if (drained !== 1'b0) begin n_fail++; $display("FAIL rst_drained: got %0b want 0", drained); end
        n_cmp++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL rst_overflow: got %0b want 0", overflow); end
        n_cmp++; if (r4_credits !== 3'd4) begin n_fail++; $display("FAIL rst_credits4: got %0d want 4", r4_credits); end
    endtask

    task automatic test_round_robin;
        logic [1:0]    exp_rdy;
        logic [PW-1:0] exp_data;
        do_reset();
        req_v = 2'b11; ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            req_data = {16'h2000 + 16'(i), 16'h1000 + 16'(i)};
            exp_rdy  = (i % 2 == 0) ? 2'b01 : 2'b10;
            exp_data = (i % 2 == 0) ? 16'h1000 + 16'(i) : 16'h2000 + 16'(i);
            #1;
            if (i == 0) begin
                n_cmp++; if (v_o !== 1'b0) begin n_fail++; $display("FAIL rr_v_first: got %0b want 0", v_o); end
            end
            n_cmp++; if (req_ready !== exp_rdy) begin n_fail++; $display("FAIL rr_ready[%0d]: got %b want %b", i, req_ready, exp_rdy); end
            tick();
            n_cmp++; if (v_o !== 1'b1) begin n_fail++; $display("FAIL rr_v[%0d]: got %0b want 1", i, v_o); end
            n_cmp++; if (grant_id !== 1'(i % 2)) begin n_fail++; $display("FAIL rr_grant[%0d]: got %0b want %0d", i, grant_id, i % 2); end
            n_cmp++; if (data_o !== exp_data) begin n_fail++; $display("FAIL rr_data[%0d]: got %h want %h", i, data_o, exp_data); end
        end
        req_v = 2'b00;
        n_cmp++; if (credits !== 8'd122) begin n_fail++; $display("FAIL rr_credits: got %0d want 122", credits); end
    endtask

    task automatic test_credit_limit;
        int acc;
        do_reset();
        r4_v = 2'b01; r4_data = {16'h0000, 16'h00AB}; r4_ready_i = 1'b1;
        acc = 0;
        for (int i = 0; i < 8; i++) begin
            #1;
            if (r4_ready[0] === 1'b1) acc++;
            tick();
        end
        n_cmp++; if (acc !== 4) begin n_fail++; $display("FAIL cl_accepts: got %0d want 4", acc); end
        n_cmp++; if (r4_credits !== 3'd0) begin n_fail++; $display("FAIL cl_credits0: got %0d want 0", r4_credits); end
        r4_cret = 1'b1;
        #1;
        n_cmp++; if (r4_ready !== 2'b00) begin n_fail++; $display("FAIL cl_ready0: got %b want 00", r4_ready); end
        tick();
        r4_cret = 1'b0;
        acc = 0;
        for (int i = 0; i < 4; i++) begin
            #1;
            if (r4_ready[0] === 1'b1) acc++;
            tick();
        end
        n_cmp++; if (acc !== 1) begin n_fail++; $display("FAIL cl_one_more: got %0d want 1", acc); end
        n_cmp++; if (r4_credits !== 3'd0) begin n_fail++; $display("FAIL cl_credits_end: got %0d want 0", r4_credits); end
        r4_v = 2'b00;
    endtask

    task automatic test_backpressure;
        do_reset();
        req_v = 2'b01; req_data = {16'h5555, 16'hAAAA}; ready = 1'b0;
        #1;
        n_cmp++; if (req_ready !== 2'b01) begin n_fail++; $display("FAIL bp_first: got %b want 01", req_ready); end
        tick();
        req_v = 2'b11;
        for (int i = 0; i < 5; i++) begin
            #1;
            n_cmp++; if (req_ready !== 2'b00) begin n_fail++; $display("FAIL bp_ready[%0d]: got %b want 00", i, req_ready); end
            n_cmp++; if (v_o !== 1'b1) begin n_fail++; $display("FAIL bp_v[%0d]: got %0b want 1", i, v_o); end
            n_cmp++; if (data_o !== 16'hAAAA) begin n_fail++; $display("FAIL bp_data[%0d]: got %h want aaaa", i, data_o); end
            n_cmp++; if (grant_id !== 1'b0) begin n_fail++; $display("FAIL bp_grant[%0d]: got %0b want 0", i, grant_id); end
            tick();
        end
        ready = 1'b1;
        #1;
        n_cmp++; if (req_ready !== 2'b10) begin n_fail++; $display("FAIL bp_release: got %b want 10", req_ready); end
        tick();
        req_v = 2'b00;
        n_cmp++; if (data_o !== 16'h5555) begin n_fail++; $display("FAIL bp_next_data: got %h want 5555", data_o); end
        n_cmp++; if (grant_id !== 1'b1) begin n_fail++; $display("FAIL bp_next_grant: got %0b want 1", grant_id); end
    endtask

    task automatic test_drain;
        do_reset();
        req_v = 2'b01; req_data = {16'h0000, 16'h0C0C}; ready = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        n_cmp++; if (credits !== 8'd125) begin n_fail++; $display("FAIL dr_credits125: got %0d want 125", credits); end
        drain = 1'b1;
        #1;
        n_cmp++; if (req_ready !== 2'b00) begin n_fail++; $display("FAIL dr_suppress: got %b want 00", req_ready); end
        tick();
        n_cmp++; if (v_o !== 1'b0) begin n_fail++; $display("FAIL dr_handoff: got %0b want 0", v_o); end
        for (int i = 0; i < 3; i++) begin
            cret = 1'b1;
            #1;
            n_cmp++; if (req_ready !== 2'b00) begin n_fail++; $display("FAIL dr_ready[%0d]: got %b want 00", i, req_ready); end
            tick();
            n_cmp++; if (drained !== 1'b0) begin n_fail++; $display("FAIL dr_early[%0d]: got %0b want 0", i, drained); end
        end
        cret = 1'b0;
        n_cmp++; if (credits !== 8'd128) begin n_fail++; $display("FAIL dr_full: got %0d want 128", credits); end
        tick();
        n_cmp++; if (drained !== 1'b1) begin n_fail++; $display("FAIL dr_done: got %0b want 1", drained); end
        drain = 1'b0;
        #1;
        n_cmp++; if (req_ready !== 2'b00) begin n_fail++; $display("FAIL dr_done_ready: got %b want 00", req_ready); end
        tick();
        n_cmp++; if (drained !== 1'b0) begin n_fail++; $display("FAIL dr_resume: got %0b want 0", drained); end
        n_cmp++; if (req_ready !== 2'b01) begin n_fail++; $display("FAIL dr_run_ready: got %b want 01", req_ready); end
        req_v = 2'b00;
    endtask

    task automatic test_overflow;
        do_reset();
        cret = 1'b1;
        tick();
        cret = 1'b0;
        n_cmp++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL of_set: got %0b want 1", overflow); end
        n_cmp++; if (credits !== 8'd128) begin n_fail++; $display("FAIL of_sat: got %0d want 128", credits); end
        repeat (3) tick();
        req_v = 2'b01; req_data = {16'h0, 16'h0F0F};
        tick();
        req_v = 2'b00;
        n_cmp++; if (credits !== 8'd127) begin n_fail++; $display("FAIL of_accept: got %0d want 127", credits); end
        n_cmp++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL of_sticky: got %0b want 1", overflow); end
        do_reset();
        n_cmp++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL of_clear: got %0b want 0", overflow); end
    endtask

    task automatic test_async_reset;
        do_reset();
        req_v = 2'b01; req_data = {16'h0, 16'h7777}; ready = 1'b1;
        repeat (28) tick();
        req_v = 2'b00;
        n_cmp++; if (credits !== 8'd100) begin n_fail++; $display("FAIL ar_pre_credits: got %0d want 100", credits); end
        n_cmp++; if (v_o !== 1'b1) begin n_fail++; $display("FAIL ar_pre_v: got %0b want 1", v_o); end
        #2;
        reset_i = 1'b1;
        #1;
        n_cmp++; if (v_o !== 1'b0) begin n_fail++; $display("FAIL ar_v: got %0b want 0", v_o); end
        n_cmp++; if (credits !== 8'd128) begin n_fail++; $display("FAIL ar_credits: got %0d want 128", credits); end
        n_cmp++; if (drained !== 1'b0) begin n_fail++; $display("FAIL ar_drained: got %0b want 0", drained); end
        n_cmp++; if (data_o !== 16'h0) begin n_fail++; $display("FAIL ar_data: got %h want 0000", data_o); end
        reset_i = 1'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_credit_limit();
        test_backpressure();
        test_drain();
        test_overflow();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
